hamming_dm_engine: RTL and testbench
====================================

Name: hamming_dm_engine

Overview:
- Hardware SECDED (16,11) Hamming engine; successor to the software encode program (program 1), with a decode/correct mode (program 2) added.
- Walks NUM_MSG messages in data memory, encodes or decodes each, and writes results back.
- Sits beside the core and shares the data-memory port through a mux while busy.
- Start/halt handshake matches TopLevel's start/halt.

Parameters:
- ADDR_W, 8, data-memory address width.
- NUM_MSG, 15, number of messages processed per run (1..2^(ADDR_W-2)).
- ENC_SRC, 0, encode-mode source base (byte address).
- ENC_DST, 30, encode-mode destination base.
- DEC_SRC, 30, decode-mode source base.
- DEC_DST, 0, decode-mode destination base.

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0=encode, 1=decode; latched when start is accepted
- halt  out  1  done; high from run completion until the next accepted start
- busy  out  1  high while the FSM is not in IDLE/DONE
- mem_addr  out  ADDR_W  data-memory address
- mem_wr_en  out  1  write strobe
- mem_wr_data  out  8  write byte
- mem_rd_data  in  8  read byte; synchronous, valid the cycle after mem_addr is presented
- sec_cnt  out  8  (ERR_COUNT_EN only) number of single errors corrected
- ded_cnt  out  8  (ERR_COUNT_EN only) number of double errors detected

Behaviour:
- Reset (asynchronous) drives all outputs to 0: halt, busy, mem_wr_en, mem_addr, mem_wr_data, and the counters. The FSM goes to IDLE and the message index goes to 0. A reset mid-run abandons the run; bytes already written stay written.
- Message i location: low byte at base+2i, high byte at base+2i+1.
- Encode input layout: high byte = {5'b0, d[11:9]}, low byte = d[8:1].
- Codeword bit map, w[15:0]:
  - w0 = p0; w1 = p1; w2 = p2; w3 = d1; w4 = p4; w[7:5] = d[4:2]; w8 = p8; w[15:9] = d[11:5].
- Parity equations:
  - p1 = XOR of w at positions 3,5,7,9,11,13,15.
  - p2 = XOR of w at positions 3,6,7,10,11,14,15.
  - p4 = XOR of w at positions 5,6,7,12,13,14,15.
  - p8 = XOR of w[15:9].
  - p0 = XOR of w[15:1].
- Decode:
  - Syndrome s[3:0] = XOR of the position indices of all set bits in w[15:1].
  - Overall parity q = ^w.
  - q=0, s=0: no error, status 2'b00.
  - q=1: single error, status 2'b01. If s≠0, flip w[s]; if s=0, the error is in p0.
  - q=0, s≠0: double error, status 2'b10; data is passed through uncorrected.
  - Decode output: high byte = {status, 3'b000, d[11:9]}, low byte = d[8:1].
- FSM: IDLE → RD_LO → RD_HI → CAPT → COMP → WR_LO → WR_HI → (RD_LO | DONE).
  - IDLE: on start, latch mode, set i=0, clear halt, go to RD_LO. With no start, stay.
  - RD_LO: mem_addr = src+2i.
  - RD_HI: capture the low byte; mem_addr = src+2i+1.
  - CAPT: capture the high byte.
  - COMP: register the encoded or decoded 16-bit result.
  - WR_LO: mem_wr_en=1, mem_addr = dst+2i, mem_wr_data = result[7:0].
  - WR_HI: mem_wr_en=1, mem_addr = dst+2i+1, mem_wr_data = result[15:8]. If i == NUM_MSG-1, go to DONE; otherwise i++ and go to RD_LO.
  - DONE: halt=1. A start here restarts the run exactly as in IDLE.
- Timing:
  - 6 cycles per message.
  - halt rises 6*NUM_MSG+1 cycles after the start sample edge.
  - mem_wr_en is never high outside WR_LO/WR_HI.
- start while busy is ignored; mode changes while busy are ignored.
- Address arithmetic is modulo 2^ADDR_W (wraps).

Optional Feature:
- Macro: HAMMING_ERR_COUNT_EN.
- Defined:
  - sec_cnt and ded_cnt ports exist.
  - Both clear on an accepted start.
  - In decode COMP, the counter matching the status increments; counters saturate at 255.
  - Encode mode leaves both at 0.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Encode, NUM_MSG=2, inputs d=11'h000 and 11'h7FF (mem[0..3] = 00,00,FF,07) → mem[30..33] = 00,00,FF,FF; halt at cycle 13 after start.
- Decode, mem[30..31] = FE,FF (p0 flipped from FFFF) → mem[0] = FF, mem[1] = 47; sec_cnt = 1 if enabled.
- Decode, 0xFFFC (two bits flipped) → low byte FF, high byte 87; ded_cnt = 1 if enabled.
- Decode, 0xFFF7 (d1, position 3, flipped) → corrected: low byte FF, high byte 47.
- Reset asserted during the WR_LO of message 1 → outputs 0 immediately, halt stays 0; a new start reruns all 15 messages correctly (15 random messages checked against the reference model).
- start pulsed while busy, and at DONE → the busy pulse is ignored; the DONE pulse clears halt and restarts with the new mode.

Source files
------------

// File: rtl/hamming_dm_engine.sv
// SECDED (16,11) Hamming engine: walks NUM_MSG messages in data memory, encoding or decoding each.
// Optional error counters (sec_cnt/ded_cnt) are built when HAMMING_ERR_COUNT_EN is defined.
module hamming_dm_engine #(
    parameter int ADDR_W  = 8,
    parameter int NUM_MSG = 15,
    parameter int ENC_SRC = 0,
    parameter int ENC_DST = 30,
    parameter int DEC_SRC = 30,
    parameter int DEC_DST = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              start,
    input  logic              mode,
    output logic              halt,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    input  logic [7:0]        mem_rd_data
`ifdef HAMMING_ERR_COUNT_EN
    ,
    output logic [7:0]        sec_cnt,
    output logic [7:0]        ded_cnt
`endif
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] CAPT  = 3'd3;
    localparam logic [2:0] COMP  = 3'd4;
    localparam logic [2:0] WR_LO = 3'd5;
    localparam logic [2:0] WR_HI = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic              mode_q;
    logic [7:0]        lo_q;
    logic [7:0]        hi_q;
    logic [15:0]       result;

    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W-1:0] offset;

    assign src_base = mode_q ? ADDR_W'(DEC_SRC) : ADDR_W'(ENC_SRC);
    assign dst_base = mode_q ? ADDR_W'(DEC_DST) : ADDR_W'(ENC_DST);
    assign offset   = {idx[ADDR_W-2:0], 1'b0};
    assign busy     = (state != IDLE) && (state != DONE);

    // Encoder: scatter d[11:1] into the non-power-of-two positions, then fill parity.
    logic [10:0] enc_d;
    logic [15:0] enc_base;
    logic        p1, p2, p4, p8, p0;
    logic [15:0] enc_w;

    assign enc_d    = {hi_q[2:0], lo_q};
    assign enc_base = {enc_d[10:4], 1'b0, enc_d[3:1], 1'b0, enc_d[0], 3'b000};
    assign p1       = ^(enc_base & 16'hAAA8);
    assign p2       = ^(enc_base & 16'hCCC8);
    assign p4       = ^(enc_base & 16'hF0E0);
    assign p8       = ^(enc_base & 16'hFE00);
    assign p0       = (^enc_base) ^ p1 ^ p2 ^ p4 ^ p8;
    assign enc_w    = enc_base | {7'b0, p8, 3'b000, p4, 1'b0, p2, p1, p0};

    logic [15:0] dec_w;
    logic [3:0]  syn;
    logic        q;
    logic [1:0]  status;
    logic [15:0] fixed;
    logic [15:0] dec_result;

    assign dec_w  = {hi_q, lo_q};
    assign syn    = {^(dec_w & 16'hFF00), ^(dec_w & 16'hF0F0),
                     ^(dec_w & 16'hCCCC), ^(dec_w & 16'hAAAA)};
    assign q      = ^dec_w;
    assign status = q ? 2'b01 : ((syn != 4'd0) ? 2'b10 : 2'b00);
    // A single error at position 0 needs no data fix; double errors pass through untouched.
    assign fixed  = (q && (syn != 4'd0)) ? (dec_w ^ (16'h1 << syn)) : dec_w;
    assign dec_result = {status, 3'b000, fixed[15:13],
                         fixed[12:9], fixed[7:5], fixed[3]};

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            RD_LO: mem_addr = src_base + offset;
            RD_HI: mem_addr = src_base + offset + ADDR_W'(1);
            WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dst_base + offset;
                mem_wr_data = result[7:0];
            end
            WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = dst_base + offset + ADDR_W'(1);
                mem_wr_data = result[15:8];
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            idx     <= '0;
            mode_q  <= 1'b0;
            halt    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            result  <= '0;
`ifdef HAMMING_ERR_COUNT_EN
            sec_cnt <= '0;
            ded_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q  <= mode;
                        idx     <= '0;
                        halt    <= 1'b0;
                        state   <= RD_LO;
`ifdef HAMMING_ERR_COUNT_EN
                        sec_cnt <= '0;
                        ded_cnt <= '0;
`endif
                    end else if (state == DONE) begin
                        halt <= 1'b1;
                    end
                end
                RD_LO: state <= RD_HI;
                RD_HI: begin
                    lo_q  <= mem_rd_data;
                    state <= CAPT;
                end
                CAPT: begin
                    hi_q  <= mem_rd_data;
                    state <= COMP;
                end
                COMP: begin
                    result <= mode_q ? dec_result : enc_w;
`ifdef HAMMING_ERR_COUNT_EN
                    if (mode_q && (status == 2'b01) && (sec_cnt != 8'hFF))
                        sec_cnt <= sec_cnt + 8'd1;
                    if (mode_q && (status == 2'b10) && (ded_cnt != 8'hFF))
                        ded_cnt <= ded_cnt + 8'd1;
`endif
                    state <= WR_LO;
                end
                WR_LO: state <= WR_HI;
                WR_HI: begin
                    if (idx == ADDR_W'(NUM_MSG - 1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= RD_LO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_dm_engine.sv
// Randomized self-checking bench for hamming_dm_engine against a nearest-codeword reference model.
module tb_hamming_dm_engine;

    localparam int ADDR_W  = 8;
    localparam int NUM_MSG = 15;
    localparam int ENC_SRC = 0;
    localparam int ENC_DST = 30;
    localparam int DEC_SRC = 30;
    localparam int DEC_DST = 0;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic              CLK = 1'b0;
    logic              Reset = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic              halt;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic [7:0]        mem_rd_data;
`ifdef HAMMING_ERR_COUNT_EN
    logic [7:0]        sec_cnt;
    logic [7:0]        ded_cnt;
`endif

    logic [7:0]  mem [256];
    logic [15:0] exp_word [NUM_MSG];
    int          exp_sec;
    int          exp_ded;
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;

    hamming_dm_engine #(
        .ADDR_W(ADDR_W), .NUM_MSG(NUM_MSG),
        .ENC_SRC(ENC_SRC), .ENC_DST(ENC_DST),
        .DEC_SRC(DEC_SRC), .DEC_DST(DEC_DST)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .start(start),
        .mode(mode),
        .halt(halt),
        .busy(busy),
        .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
`ifdef HAMMING_ERR_COUNT_EN
        ,
        .sec_cnt(sec_cnt),
        .ded_cnt(ded_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Synchronous-read data memory: read data reflects the address of the previous cycle.
    always @(posedge CLK) begin
        mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_encode(input logic [10:0] d);
        logic [15:0] w;
        logic        par;
        w = '0;
        for (int j = 0; j < 11; j++) w[DPOS[j]] = d[j];
        for (int p = 1; p < 16; p = p * 2) begin
            par = 1'b0;
            for (int k = 1; k < 16; k++)
                if (((k & p) != 0) && (k != p)) par = par ^ w[k];
            w[p] = par;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] ref_data(input logic [15:0] w);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = w[DPOS[j]];
        return d;
    endfunction

    // Valid codeword -> clean; one flip away from a codeword -> corrected; otherwise double error.
    function automatic logic [17:0] ref_decode(input logic [15:0] w);
        logic [1:0]  st;
        logic [15:0] c;
        logic [10:0] d;
        st = 2'b10;
        d  = ref_data(w);
        if (ref_encode(ref_data(w)) == w) begin
            st = 2'b00;
        end else begin
            for (int b = 0; b < 16; b++) begin
                c = w ^ (16'h1 << b);
                if (st == 2'b10 && ref_encode(ref_data(c)) == c) begin
                    st = 2'b01;
                    d  = ref_data(c);
                end
            end
        end
        return {st, st, 3'b000, d[10:8], d[7:0]};
    endfunction

    task automatic load_encode(input bit directed);
        logic [10:0] d;
        for (int i = 0; i < NUM_MSG; i++) begin
            d = 11'($urandom);
            if (directed && i == 0) d = 11'h000;
            if (directed && i == 1) d = 11'h7FF;
            mem[8'(ENC_SRC + 2*i)]     = d[7:0];
            mem[8'(ENC_SRC + 2*i + 1)] = {5'b0, d[10:8]};
            exp_word[i] = ref_encode(d);
        end
        exp_sec = 0;
        exp_ded = 0;
    endtask

    task automatic load_decode();
        logic [15:0] w;
        logic [17:0] r;
        int          b1, b2, nflip;
        exp_sec = 0;
        exp_ded = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            w     = ref_encode(11'($urandom));
            nflip = $urandom_range(0, 2);
            b1    = $urandom_range(0, 15);
            b2    = (b1 + $urandom_range(1, 15)) % 16;
            if (nflip >= 1) w = w ^ (16'h1 << b1);
            if (nflip == 2) w = w ^ (16'h1 << b2);
            if (i == 0) w = 16'hFFFE;
            if (i == 1) w = 16'hFFFC;
            if (i == 2) w = 16'hFFF7;
            mem[8'(DEC_SRC + 2*i)]     = w[7:0];
            mem[8'(DEC_SRC + 2*i + 1)] = w[15:8];
            r = ref_decode(w);
            exp_word[i] = r[15:0];
            if (r[17:16] == 2'b01) exp_sec++;
            if (r[17:16] == 2'b10) exp_ded++;
        end
    endtask

    task automatic check_results(input logic m);
        int dst;
        dst = m ? DEC_DST : ENC_DST;
        for (int i = 0; i < NUM_MSG; i++)
            check($sformatf("msg%0d_mode%0d", i, m),
                  {mem[8'(dst + 2*i + 1)], mem[8'(dst + 2*i)]}, exp_word[i]);
    endtask

    // Start a run; optionally pulse start (with the other mode) while busy at cycle glitch_at.
    task automatic run(input logic m, input int glitch_at);
        int cyc;
        int base;
        bit done;
        base = wr_cnt;
        @(negedge CLK);
        start = 1'b1;
        mode  = m;
        @(posedge CLK);
        #1;
        start = 1'b0;
        mode  = 1'($urandom);
        check("busy_after_start", busy, 1);
        check("halt_after_start", halt, 0);
        cyc  = 0;
        done = 0;
        while (!done && cyc < 200) begin
            if (glitch_at != 0 && cyc == glitch_at) begin
                @(negedge CLK);
                start = 1'b1;
                mode  = ~m;
                @(posedge CLK);
                #1;
                start = 1'b0;
            end else begin
                @(posedge CLK);
                #1;
            end
            cyc++;
            if (halt) done = 1;
        end
        check("halt_latency", cyc, 6*NUM_MSG + 1);
        check("write_count", wr_cnt - base, 2*NUM_MSG);
    endtask

    initial begin
        bit found;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        #12;
        check("rst_halt", halt, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("idle_busy", busy, 0);
        check("idle_halt", halt, 0);

        load_encode(1);
        run(1'b0, 0);
        check_results(1'b0);
        check("enc_000_lo", mem[8'(ENC_DST)], 8'h00);
        check("enc_000_hi", mem[8'(ENC_DST + 1)], 8'h00);
        check("enc_7ff_lo", mem[8'(ENC_DST + 2)], 8'hFF);
        check("enc_7ff_hi", mem[8'(ENC_DST + 3)], 8'hFF);
`ifdef HAMMING_ERR_COUNT_EN
        check("enc_sec_cnt", sec_cnt, 0);
        check("enc_ded_cnt", ded_cnt, 0);
`endif
        repeat (3) @(posedge CLK);
        #1;
        check("done_halt_hold", halt, 1);
        check("done_busy", busy, 0);
        check("done_wr_en", mem_wr_en, 0);

        // Restart from DONE in decode mode, with an ignored start pulse mid-run.
        load_decode();
        run(1'b1, 10);
        check_results(1'b1);
        check("dec_p0_lo", mem[8'(DEC_DST)], 8'hFF);
        check("dec_p0_hi", mem[8'(DEC_DST + 1)], 8'h47);
        check("dec_dbl_lo", mem[8'(DEC_DST + 2)], 8'hFF);
        check("dec_dbl_hi", mem[8'(DEC_DST + 3)], 8'h87);
        check("dec_d1_lo", mem[8'(DEC_DST + 4)], 8'hFF);
        check("dec_d1_hi", mem[8'(DEC_DST + 5)], 8'h47);
`ifdef HAMMING_ERR_COUNT_EN
        check("dec_sec_cnt", sec_cnt, exp_sec);
        check("dec_ded_cnt", ded_cnt, exp_ded);
`endif

        // Reset during WR_LO of message 1 abandons the run.
        load_encode(0);
        mem[8'(ENC_DST + 2)] = 8'hA5;
        mem[8'(ENC_DST + 3)] = 8'hA5;
        @(negedge CLK);
        start = 1'b1;
        mode  = 1'b0;
        @(posedge CLK);
        #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (mem_wr_en && mem_addr == 8'(ENC_DST + 2)) found = 1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        check("wr_lo_msg1_seen", found, 1);
        Reset = 1'b1;
        #1;
        check("midrst_halt", halt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", mem_wr_en, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wr_data", mem_wr_data, 0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("postrst_halt", halt, 0);
        check("postrst_busy", busy, 0);
        check("kept_msg0", {mem[8'(ENC_DST + 1)], mem[8'(ENC_DST)]}, exp_word[0]);
        check("unwritten_msg1", mem[8'(ENC_DST + 2)], 8'hA5);

        load_encode(0);
        run(1'b0, 0);
        check_results(1'b0);
`ifdef HAMMING_ERR_COUNT_EN
        check("rerun_sec_cnt", sec_cnt, 0);
        check("rerun_ded_cnt", ded_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
